// File: rtl/wfg_regbank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wfg_regbank_pkg
// Purpose  : Shared constants, response type and byte-lane merge helper for
//            the waveform-generator Wishbone register bank.
// Contents : WORD_STRIDE / OFFS_W  - byte stride of one word register
//            MAXREGS               - upper limit on the register count
//            DATA_W / SEL_W        - bus data width and byte-lane count
//            wb_resp_t             - registered bus response {ack, err, rdata}
//            byte_merge()          - byte-lane write merge under a bit mask
// Revision : 1.0 - initial release
// ============================================================================
package wfg_regbank_pkg;

  localparam int WORD_STRIDE = 4;
  localparam int OFFS_W      = $clog2(WORD_STRIDE);
  localparam int MAXREGS     = 64;
  localparam int DATA_W      = 32;
  localparam int SEL_W       = DATA_W / 8;

  typedef struct packed {
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } wb_resp_t;

  // Replace only the selected byte lanes, then keep unimplemented bits at
  // their old value so they can never be set by software.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_val,
    input logic [DATA_W-1:0] new_val,
    input logic [SEL_W-1:0]  sel,
    input logic [DATA_W-1:0] mask
  );
    logic [DATA_W-1:0] merged;
    merged = old_val;
    for (int k = 0; k < SEL_W; k++) begin
      if (sel[k]) begin
        merged[k*8 +: 8] = new_val[k*8 +: 8];
      end
    end
    return (old_val & ~mask) | (merged & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wfg_regbank_decode.sv
`default_nettype none
// ============================================================================
// Module   : wfg_regbank_decode
// Purpose  : Combinational address decoder for the register bank. Turns a
//            byte address and the write enable into a word index plus
//            hit / read-only-hit / error flags.
// Ports    : adr_i    in  AW    decoded byte-address bits
//            we_i     in  1     write enable of the current request
//            idx_o    out IDXW  word register index (adr_i[AW-1:2])
//            hit_o    out 1     index in range and word aligned
//            ro_hit_o out 1     hit on a read-only register
//            err_o    out 1     request must be answered with an error
// Revision : 1.0 - initial release
// ============================================================================
module wfg_regbank_decode
  import wfg_regbank_pkg::*;
#(
  parameter  int               NREGS   = 8,
  parameter  int               AW      = 12,
  parameter  logic [NREGS-1:0] RO_MASK = '0,
  localparam int               IDXW    = AW - OFFS_W
) (
  input  logic [AW-1:0]   adr_i,
  input  logic            we_i,
  output logic [IDXW-1:0] idx_o,
  output logic            hit_o,
  output logic            ro_hit_o,
  output logic            err_o
);

  logic w_aligned;

  assign idx_o     = adr_i[AW-1:OFFS_W];
  assign w_aligned = (adr_i[OFFS_W-1:0] == '0);

  // Range check is done by matching against every implemented index, which
  // also keeps the RO_MASK lookup in bounds for out-of-range addresses.
  always_comb begin
    hit_o    = 1'b0;
    ro_hit_o = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx_o == IDXW'(i)) begin
        hit_o    = w_aligned;
        ro_hit_o = w_aligned && RO_MASK[i];
      end
    end
  end

  assign err_o = !hit_o || (we_i && ro_hit_o);

endmodule
`default_nettype wire

// File: rtl/wfg_wb_regbank.sv
`default_nettype none
// ============================================================================
// Module   : wfg_wb_regbank
// Purpose  : Generic Wishbone B4 classic slave register bank for waveform
//            generator blocks. NREGS word registers with byte-lane writes,
//            implemented-bit masks, read-only status registers, error
//            responses and a one-cycle write pulse per register.
// Config   : WFG_REGBANK_SHADOW_EN - when defined, writes land in a shadow
//            bank and reg_q_o loads all shadows on commit_i.
// Ports    : wb_clk_i        in  1           clock
//            wb_rst_i        in  1           synchronous active-high reset
//            wbs_stb_i/cyc_i/we_i in 1 each  Wishbone strobe/cycle/write
//            wbs_sel_i       in  BUSW/8      byte lane selects
//            wbs_adr_i       in  BUSW        byte address
//            wbs_dat_i       in  BUSW        write data
//            wbs_ack_o       out 1           transfer acknowledge
//            wbs_err_o       out 1           transfer error
//            wbs_dat_o       out BUSW        registered read data
//            reg_q_o         out NREGS*BUSW  live register values
//            reg_wr_pulse_o  out NREGS       pulse per accepted write
//            ro_d_i          in  NREGS*BUSW  status for read-only registers
//            commit_i        in  1           shadow commit strobe
// Revision : 1.0 - initial release
// ============================================================================
module wfg_wb_regbank
  import wfg_regbank_pkg::*;
#(
  parameter int                    BUSW      = 32,
  parameter int                    NREGS     = 8,
  parameter int                    AW        = 12,
  parameter logic [NREGS*BUSW-1:0] RESET_VAL = '0,
  parameter logic [NREGS*BUSW-1:0] WMASK     = '1,
  parameter logic [NREGS-1:0]      RO_MASK   = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [BUSW/8-1:0]     wbs_sel_i,
  input  logic [BUSW-1:0]       wbs_adr_i,
  input  logic [BUSW-1:0]       wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic [BUSW-1:0]       wbs_dat_o,
  output logic [NREGS*BUSW-1:0] reg_q_o,
  output logic [NREGS-1:0]      reg_wr_pulse_o,
  input  logic [NREGS*BUSW-1:0] ro_d_i,
  input  logic                  commit_i
);

  localparam int IDXW = AW - OFFS_W;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [BUSW-1:0] regs_q [NREGS];
  logic [BUSW-1:0] regs_d [NREGS];
  wb_resp_t        resp_q;
  wb_resp_t        resp_d;
  logic [NREGS-1:0] pulse_q;
  logic [NREGS-1:0] pulse_d;

  // Register contents as seen by bus reads of RW registers.
  logic [BUSW-1:0] w_rw_view [NREGS];

  logic [IDXW-1:0] w_idx;
  logic            w_hit;
  logic            w_ro_hit;
  logic            w_err;
  logic            w_req;
  logic            w_wr_ok;
  logic [BUSW-1:0] w_rd_data;
  logic            w_unused;

  // --------------------------------------------------------------------------
  // Decode and request qualification
  // --------------------------------------------------------------------------
  wfg_regbank_decode #(
    .NREGS   (NREGS),
    .AW      (AW),
    .RO_MASK (RO_MASK)
  ) u_decode (
    .adr_i    (wbs_adr_i[AW-1:0]),
    .we_i     (wbs_we_i),
    .idx_o    (w_idx),
    .hit_o    (w_hit),
    .ro_hit_o (w_ro_hit),
    .err_o    (w_err)
  );

  // Gating by the pending response makes a held strobe get served every
  // second cycle, matching classic single-cycle ack handshakes.
  assign w_req   = wbs_stb_i & wbs_cyc_i & ~resp_q.ack & ~resp_q.err;
  assign w_wr_ok = w_req & wbs_we_i & ~w_err;

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
`ifdef WFG_REGBANK_SHADOW_EN
  logic [BUSW-1:0] shadow_q [NREGS];
  logic [BUSW-1:0] shadow_d [NREGS];

  // The commit copies shadow_d rather than shadow_q so that a write landing
  // on the commit edge is carried straight into the live bank.
  always_comb begin
    shadow_d = shadow_q;
    pulse_d  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (w_wr_ok && (w_idx == IDXW'(i))) begin
        shadow_d[i] = byte_merge(shadow_q[i], wbs_dat_i, wbs_sel_i,
                                 WMASK[i*BUSW +: BUSW]);
        pulse_d[i]  = 1'b1;
      end
    end
    if (commit_i) begin
      regs_d = shadow_d;
    end else begin
      regs_d = regs_q;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_q[i] <= RESET_VAL[i*BUSW +: BUSW] & WMASK[i*BUSW +: BUSW];
      end
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign w_rw_view = shadow_q;
  assign w_unused  = &{1'b0, wbs_adr_i[BUSW-1:AW]};
`else
  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (w_wr_ok && (w_idx == IDXW'(i))) begin
        regs_d[i]  = byte_merge(regs_q[i], wbs_dat_i, wbs_sel_i,
                                WMASK[i*BUSW +: BUSW]);
        pulse_d[i] = 1'b1;
      end
    end
  end

  assign w_rw_view = regs_q;
  assign w_unused  = &{1'b0, wbs_adr_i[BUSW-1:AW], commit_i};
`endif

  // --------------------------------------------------------------------------
  // Read path and response
  // --------------------------------------------------------------------------
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (w_idx == IDXW'(i)) begin
        if (RO_MASK[i]) begin
          w_rd_data = ro_d_i[i*BUSW +: BUSW] & WMASK[i*BUSW +: BUSW];
        end else begin
          w_rd_data = w_rw_view[i] & WMASK[i*BUSW +: BUSW];
        end
      end
    end
  end

  // rdata stays zero for errors and write acks, so wbs_dat_o only carries
  // data in a read-ack cycle.
  always_comb begin
    resp_d = '0;
    if (w_req) begin
      if (w_err) begin
        resp_d.err = 1'b1;
      end else begin
        resp_d.ack = 1'b1;
        if (!wbs_we_i) begin
          resp_d.rdata = w_rd_data;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL[i*BUSW +: BUSW] & WMASK[i*BUSW +: BUSW];
      end
      resp_q  <= '0;
      pulse_q <= '0;
    end else begin
      regs_q  <= regs_d;
      resp_q  <= resp_d;
      pulse_q <= pulse_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign wbs_ack_o      = resp_q.ack;
  assign wbs_err_o      = resp_q.err;
  assign wbs_dat_o      = resp_q.rdata;
  assign reg_wr_pulse_o = pulse_q;

  // Read-only registers pass status straight through to the core side.
  always_comb begin
    reg_q_o = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (RO_MASK[i]) begin
        reg_q_o[i*BUSW +: BUSW] = ro_d_i[i*BUSW +: BUSW] & WMASK[i*BUSW +: BUSW];
      end else begin
        reg_q_o[i*BUSW +: BUSW] = regs_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wfg_wb_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_wfg_wb_regbank
// Purpose  : Self-checking bench for wfg_wb_regbank. Stimulus pushes the
//            expected response into a scoreboard queue; a negedge monitor
//            pops and compares whenever ack or err is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wfg_wb_regbank;

  localparam int BUSW  = 32;
  localparam int NREGS = 8;
  localparam int AW    = 12;
  localparam int VW    = NREGS * BUSW;

  localparam logic [VW-1:0] TB_RESET = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0,
                                        32'h0, 32'h0, 32'h00004000, 32'h0};
  localparam logic [VW-1:0] TB_WMASK = {32'hFFFFFFFF, 32'hFFFFFFFF,
                                        32'h0000FFFF, {5{32'hFFFFFFFF}}};
  localparam logic [NREGS-1:0] TB_RO = 8'b0000_1000;

`ifdef WFG_REGBANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       adr, dat_i;
  logic              ack, err;
  logic [31:0]       dat_o;
  logic [VW-1:0]     reg_q;
  logic [NREGS-1:0]  pulse;
  logic [VW-1:0]     ro_d;
  logic              commit;

  wfg_wb_regbank #(
    .BUSW      (BUSW),
    .NREGS     (NREGS),
    .AW        (AW),
    .RESET_VAL (TB_RESET),
    .WMASK     (TB_WMASK),
    .RO_MASK   (TB_RO)
  ) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .wbs_stb_i      (stb),
    .wbs_cyc_i      (cyc),
    .wbs_we_i       (we),
    .wbs_sel_i      (sel),
    .wbs_adr_i      (adr),
    .wbs_dat_i      (dat_i),
    .wbs_ack_o      (ack),
    .wbs_err_o      (err),
    .wbs_dat_o      (dat_o),
    .reg_q_o        (reg_q),
    .reg_wr_pulse_o (pulse),
    .ro_d_i         (ro_d),
    .commit_i       (commit)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               ack;
    bit               err;
    logic [31:0]      rdata;
    logic [NREGS-1:0] pulse;
    logic [VW-1:0]    live;
    string            name;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  logic [31:0] m_shadow [NREGS];
  logic [31:0] m_live   [NREGS];

  function automatic void check(input string name, input logic [VW-1:0] act,
                                input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] mask_of(input int i);
    return TB_WMASK[i*32 +: 32];
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_shadow[i] = TB_RESET[i*32 +: 32] & mask_of(i);
      m_live[i]   = m_shadow[i];
    end
  endfunction

  function automatic logic [VW-1:0] live_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NREGS; i++) begin
      if (TB_RO[i]) v[i*32 +: 32] = ro_d[i*32 +: 32] & mask_of(i);
      else          v[i*32 +: 32] = m_live[i];
    end
    return v;
  endfunction

  function automatic exp_t predict(input bit w, input logic [31:0] a,
                                   input logic [3:0] s, input logic [31:0] d,
                                   input bit c);
    exp_t e;
    int   idx;
    bit   hit, ro;
    idx = int'((a >> 2) & ((32'd1 << (AW - 2)) - 1));
    hit = (idx < NREGS) && (a % 4 == 0);
    ro  = 1'b0;
    if (hit) ro = TB_RO[idx];
    e.ack = 0; e.err = 0; e.rdata = 0; e.pulse = 0;
    if (!hit || (w && ro)) begin
      e.err = 1;
    end else begin
      e.ack = 1;
      if (w) begin
        for (int k = 0; k < 4; k++)
          if (s[k]) m_shadow[idx][k*8 +: 8] = d[k*8 +: 8];
        m_shadow[idx] = m_shadow[idx] & mask_of(idx);
        if (!SHADOW) m_live[idx] = m_shadow[idx];
        e.pulse[idx] = 1'b1;
      end else if (ro) begin
        e.rdata = ro_d[idx*32 +: 32] & mask_of(idx);
      end else begin
        e.rdata = m_shadow[idx] & mask_of(idx);
      end
    end
    if (SHADOW && c)
      for (int i = 0; i < NREGS; i++) m_live[i] = m_shadow[i];
    e.live = live_vec();
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic access(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit c, input string name);
    exp_t e;
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = w; adr = a; sel = s; dat_i = d; commit = c;
    e = predict(w, a, s, d, c);
    e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    stb = 0; cyc = 0; we = 0; commit = 0;
  endtask

  // Strobe held for n edges: a response is expected only every other edge.
  task automatic hold_access(input bit w, input logic [31:0] a,
                             input logic [31:0] d, input int n, input string name);
    exp_t e;
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = w; adr = a; sel = 4'hF; dat_i = d; commit = 0;
    for (int i = 0; i < n / 2; i++) begin
      e = predict(w, a, 4'hF, d, 1'b0);
      e.name = name;
      sb.push_back(e);
    end
    repeat (n) @(posedge clk);
    #1;
    stb = 0; cyc = 0; we = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ack || err) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_response: got ack=%0b err=%0b expected none", ack, err);
        end else begin
          e = sb.pop_front();
          check({e.name, "_ack"},   VW'(ack),   VW'(e.ack));
          check({e.name, "_err"},   VW'(err),   VW'(e.err));
          check({e.name, "_rdata"}, VW'(dat_o), VW'(e.rdata));
          check({e.name, "_pulse"}, VW'(pulse), VW'(e.pulse));
          check({e.name, "_regq"},  reg_q,      e.live);
        end
      end else begin
        check("idle_dat",   VW'(dat_o), '0);
        check("idle_pulse", VW'(pulse), '0);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_i = 0; commit = 0;
    ro_d = {$urandom(), $urandom(), $urandom(), $urandom(),
            32'h12345678, $urandom(), $urandom(), $urandom()};
    m_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_ack",   VW'(ack),   '0);
    check("reset_err",   VW'(err),   '0);
    check("reset_dat",   VW'(dat_o), '0);
    check("reset_pulse", VW'(pulse), '0);
    check("reset_regq",  reg_q,      live_vec());
    mon_en = 1;

    access(0, 32'h04, 4'h0, 0, 0, "rd_reset_reg1");
    access(1, 32'h08, 4'b0101, 32'hAABBCCDD, 0, "wr_bytelane_reg2");
    access(0, 32'h08, 4'hF, 0, 0, "rd_reg2");
    access(0, 32'h0C, 4'hF, 0, 0, "rd_ro_reg3");
    access(1, 32'h0C, 4'hF, 32'hFFFFFFFF, 0, "wr_ro_reg3");
    access(0, 32'h20, 4'hF, 0, 0, "rd_miss_20");
    access(1, 32'h20, 4'hF, 32'h1, 0, "wr_miss_20");
    access(0, 32'h06, 4'hF, 0, 0, "rd_misaligned");
    access(1, 32'h06, 4'hF, 32'h1, 0, "wr_misaligned");
    access(1, 32'h14, 4'hF, 32'hFFFFFFFF, 0, "wr_masked_reg5");
    access(0, 32'h14, 4'hF, 0, 0, "rd_masked_reg5");
    access(1, 32'h10, 4'h0, 32'h55555555, 0, "wr_sel0_reg4");
    hold_access(0, 32'h04, 0, 4, "held_rd");
    hold_access(1, 32'h1C, 32'hA5A5A5A5, 4, "held_wr");

    // Shadow behaviour; in the direct build the same model reduces to writes
    // appearing immediately.
    access(1, 32'h00, 4'hF, 32'h1, 0, "wr_reg0_nocommit");
    @(posedge clk); #1 commit = 1;
    if (SHADOW) for (int i = 0; i < NREGS; i++) m_live[i] = m_shadow[i];
    @(posedge clk); #1 commit = 0;
    @(negedge clk);
    check("commit_regq", reg_q, live_vec());
    access(1, 32'h00, 4'hF, 32'h2, 1, "wr_commit_same_edge");

    // Reset wins over a write sampled at the same edge.
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 1; adr = 32'h04; sel = 4'hF; dat_i = 32'hCAFEF00D; rst = 1;
    @(posedge clk); #1;
    stb = 0; cyc = 0; we = 0; rst = 0;
    m_reset();
    @(negedge clk);
    check("rst_wr_regq", reg_q, live_vec());
    access(0, 32'h04, 4'hF, 0, 0, "rd_after_rst");

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        ro_d[3*32 +: 32] = $urandom();
      end
      a = 32'($urandom_range(0, 9)) * 4;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom() & 32'hFFFFF000);
      access(1'($urandom_range(0, 1)), a, 4'($urandom()), $urandom(),
             ($urandom_range(0, 3) == 0), "rand");
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drain", VW'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
